// File: rtl/motor_cmd_shaper.sv
// Per-wheel speed command slew limiter and sign/period encoder for motor_controller.
// Define MOTOR_CMD_SHAPER_WDOG_EN to build the command watchdog and its FAULT ramp-down.
module motor_cmd_shaper #(
   parameter int         TICK_DIV   = 1000,
   parameter int         STEP       = 1,
   parameter int         WDOG_TICKS = 255,
   parameter logic [6:0] PERIOD_MIN = 7'd10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [7:0] cmd_m1,
   input  logic [7:0] cmd_m2,
   output logic       motor1_sign,
   output logic [6:0] motor1_period,
   output logic       motor2_sign,
   output logic [6:0] motor2_period,
   output logic       stopped,
   output logic       wdog_trip
);

   localparam int            TW        = $clog2(TICK_DIV);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [7:0]    STEP_V    = 8'(STEP);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } state_t;

   // -128 has no positive counterpart, so it is folded onto -127.
   function automatic logic [7:0] clamp_cmd(input logic [7:0] c);
      if (c == 8'h80) return 8'h81;
      else            return c;
   endfunction

   function automatic logic [7:0] ramp_next(input logic [7:0] cur, input logic [7:0] tgt);
      logic signed [8:0] d;
      logic signed [8:0] step9;
      d     = $signed({tgt[7], tgt}) - $signed({cur[7], cur});
      step9 = $signed({1'b0, STEP_V});
      if (d >= 9'sd0) begin
         if (d <= step9) return tgt;
         else            return cur + STEP_V;
      end else begin
         if (-d <= step9) return tgt;
         else             return cur - STEP_V;
      end
   endfunction

   function automatic logic [6:0] period_of(input logic [7:0] cur);
      logic [7:0] mag;
      logic [7:0] raw;
      mag = cur[7] ? (8'd0 - cur) : cur;
      raw = 8'd128 - mag;
      if (mag == 8'd0)                    return 7'd0;
      else if (raw < {1'b0, PERIOD_MIN}) return PERIOD_MIN;
      else                               return raw[6:0];
   endfunction

   state_t        state_r;
   state_t        state_nx;
   logic [TW-1:0] tick_cnt_r;
   logic [7:0]    tgt1_r;
   logic [7:0]    tgt2_r;
   logic [7:0]    cur1_r;
   logic [7:0]    cur2_r;
   logic          ready_r;
   logic          tick_s;
   logic          accept_s;
   logic          both_zero_s;

   assign tick_s      = (tick_cnt_r == TICK_LAST);
   assign accept_s    = cmd_valid && ready_r;
   assign both_zero_s = (cur1_r == 8'd0) && (cur2_r == 8'd0);
   assign cmd_ready   = ready_r;

`ifdef MOTOR_CMD_SHAPER_WDOG_EN
   localparam int            WW        = $clog2(WDOG_TICKS + 1);
   localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_TICKS - 1);

   logic [WW-1:0] wdog_cnt_r;
   logic          trip_r;

   // Watchdog counts ticks only while running; any accept restarts it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                          wdog_cnt_r <= '0;
      else if (state_r != RUN || accept_s) wdog_cnt_r <= '0;
      else if (tick_s)                     wdog_cnt_r <= wdog_cnt_r + WW'(1);
      else                                 wdog_cnt_r <= wdog_cnt_r;
   end

   // Sticky trip flag, cleared only by the next accepted command.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                 trip_r <= 1'b0;
      else if (state_nx == FAULT) trip_r <= 1'b1;
      else if (accept_s)          trip_r <= 1'b0;
      else                        trip_r <= trip_r;
   end

   assign wdog_trip = trip_r;
`else
   assign wdog_trip = 1'b0;
`endif

   // FSM next-state.
   always_comb begin
      state_nx = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) state_nx = RUN;
            else          state_nx = IDLE;
         end
         RUN: begin
`ifdef MOTOR_CMD_SHAPER_WDOG_EN
            if (!accept_s && tick_s && (wdog_cnt_r == WDOG_LAST)) state_nx = FAULT;
            else                                                  state_nx = RUN;
`else
            state_nx = RUN;
`endif
         end
         FAULT: begin
            if (both_zero_s) state_nx = IDLE;
            else             state_nx = FAULT;
         end
         default: state_nx = IDLE;
      endcase
   end

   // FSM state and handshake ready register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
         ready_r <= 1'b1;
      end else begin
         state_r <= state_nx;
         ready_r <= (state_nx != FAULT);
      end
   end

   // Free-running ramp tick divider.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)      tick_cnt_r <= '0;
      else if (tick_s) tick_cnt_r <= '0;
      else             tick_cnt_r <= tick_cnt_r + TW'(1);
   end

   // Targets: zeroed on entry to FAULT (never coincides with an accept).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tgt1_r <= 8'd0;
         tgt2_r <= 8'd0;
      end else if (state_nx == FAULT) begin
         tgt1_r <= 8'd0;
         tgt2_r <= 8'd0;
      end else if (accept_s) begin
         tgt1_r <= clamp_cmd(cmd_m1);
         tgt2_r <= clamp_cmd(cmd_m2);
      end else begin
         tgt1_r <= tgt1_r;
         tgt2_r <= tgt2_r;
      end
   end

   // Slew-limited wheel speeds, updated on the tick strobe only.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cur1_r <= 8'd0;
         cur2_r <= 8'd0;
      end else if (tick_s) begin
         cur1_r <= ramp_next(cur1_r, tgt1_r);
         cur2_r <= ramp_next(cur2_r, tgt2_r);
      end else begin
         cur1_r <= cur1_r;
         cur2_r <= cur2_r;
      end
   end

   // Registered sign/period bus, one edge behind the ramped speeds.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         motor1_sign   <= 1'b1;
         motor1_period <= 7'd0;
         motor2_sign   <= 1'b1;
         motor2_period <= 7'd0;
         stopped       <= 1'b1;
      end else begin
         motor1_sign   <= ~cur1_r[7];
         motor1_period <= period_of(cur1_r);
         motor2_sign   <= ~cur2_r[7];
         motor2_period <= period_of(cur2_r);
         stopped       <= both_zero_s;
      end
   end

endmodule

// File: tb/tb_motor_cmd_shaper.sv
// Scoreboard bench for motor_cmd_shaper: every change of the output bus is popped
// against the next expected snapshot queued by the stimulus thread.
module tb_motor_cmd_shaper;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       cmd_valid = 1'b0;
   logic [7:0] cmd_m1 = 8'd0;
   logic [7:0] cmd_m2 = 8'd0;
   logic       cmd_ready;
   logic       motor1_sign;
   logic [6:0] motor1_period;
   logic       motor2_sign;
   logic [6:0] motor2_period;
   logic       stopped;
   logic       wdog_trip;

   motor_cmd_shaper #(
      .TICK_DIV   (4),
      .STEP       (5),
      .WDOG_TICKS (8),
      .PERIOD_MIN (7'd10)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_m1        (cmd_m1),
      .cmd_m2        (cmd_m2),
      .motor1_sign   (motor1_sign),
      .motor1_period (motor1_period),
      .motor2_sign   (motor2_sign),
      .motor2_period (motor2_period),
      .stopped       (stopped),
      .wdog_trip     (wdog_trip)
   );

   always #5 clk = ~clk;

   // Edges since reset release; edge_n % 4 == 3 just before a tick edge.
   int edge_n;
   always @(posedge clk or negedge reset) begin
      if (!reset) edge_n <= 0;
      else        edge_n <= edge_n + 1;
   end

   typedef struct packed {
      logic       s1;
      logic [6:0] p1;
      logic       s2;
      logic [6:0] p2;
      logic       st;
      logic       tr;
      logic       rd;
   } obs_t;

   obs_t exp_q[$];
   int   n_total = 0;
   int   n_bad = 0;

   task automatic push(input logic s1, input int p1, input logic s2, input int p2,
                       input logic st, input logic tr, input logic rd);
      obs_t o;
      o.s1 = s1; o.p1 = 7'(p1); o.s2 = s2; o.p2 = 7'(p2);
      o.st = st; o.tr = tr; o.rd = rd;
      exp_q.push_back(o);
   endtask

   task automatic check(input string name, input int act, input int expv);
      n_total++;
      if (act != expv) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   task automatic send(input int m1, input int m2);
      cmd_m1    = 8'(m1);
      cmd_m2    = 8'(m2);
      cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_ticks(input int n);
      repeat (n) begin
         @(posedge clk);
         while (edge_n % 4 != 3) @(posedge clk);
      end
      @(negedge clk);
   endtask

   // Monitor: any change on the output bus must match the next queued snapshot.
   initial begin
      obs_t last_o;
      obs_t cur_o;
      obs_t e;
      last_o = 'x;
      forever begin
         @(negedge clk);
         cur_o = {motor1_sign, motor1_period, motor2_sign, motor2_period,
                  stopped, wdog_trip, cmd_ready};
         if (cur_o !== last_o) begin
            n_total++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL obs_unexpected: got s1=%b p1=%0d s2=%b p2=%0d st=%b tr=%b rd=%b expected no change",
                        cur_o.s1, cur_o.p1, cur_o.s2, cur_o.p2, cur_o.st, cur_o.tr, cur_o.rd);
            end else begin
               e = exp_q.pop_front();
               if (cur_o !== e) begin
                  n_bad++;
                  $display("FAIL obs: got s1=%b p1=%0d s2=%b p2=%0d st=%b tr=%b rd=%b expected s1=%b p1=%0d s2=%b p2=%0d st=%b tr=%b rd=%b",
                           cur_o.s1, cur_o.p1, cur_o.s2, cur_o.p2, cur_o.st, cur_o.tr, cur_o.rd,
                           e.s1, e.p1, e.s2, e.p2, e.st, e.tr, e.rd);
               end
            end
            last_o = cur_o;
         end
      end
   end

   initial begin
      // Reset state.
      push(1'b1, 0, 1'b1, 0, 1'b1, 1'b0, 1'b1);
      repeat (3) @(negedge clk);
      check("reset_ready", int'(cmd_ready), 1);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // Ramp up: m1 -> +20, m2 -> -10.
      push(1'b1, 123, 1'b0, 123, 1'b0, 1'b0, 1'b1);
      push(1'b1, 118, 1'b0, 118, 1'b0, 1'b0, 1'b1);
      push(1'b1, 113, 1'b0, 118, 1'b0, 1'b0, 1'b1);
      push(1'b1, 108, 1'b0, 118, 1'b0, 1'b0, 1'b1);
      send(20, -10);
      wait_ticks(5);
      check("rampup_p1", int'(motor1_period), 108);

      // Back down to +10, then reverse to -10 through zero.
      push(1'b1, 113, 1'b0, 118, 1'b0, 1'b0, 1'b1);
      push(1'b1, 118, 1'b0, 118, 1'b0, 1'b0, 1'b1);
      send(10, -10);
      wait_ticks(3);
      push(1'b1, 123, 1'b0, 118, 1'b0, 1'b0, 1'b1);
      push(1'b1, 0,   1'b0, 118, 1'b0, 1'b0, 1'b1);
      push(1'b0, 123, 1'b0, 118, 1'b0, 1'b0, 1'b1);
      push(1'b0, 118, 1'b0, 118, 1'b0, 1'b0, 1'b1);
      send(-10, -10);
      wait_ticks(5);
      check("reverse_s1", int'(motor1_sign), 0);

      // Clamp: -128 settles at -127, period floored at 10.
      for (int m = 15; m <= 120; m += 5)
         push(1'b0, (128 - m < 10) ? 10 : 128 - m, 1'b0, 118, 1'b0, 1'b0, 1'b1);
      repeat (5) begin
         send(-128, -10);
         wait_ticks(5);
      end
      check("clamp_p1", int'(motor1_period), 10);

      // Return to rest from -127: the step sequence exposes -127 versus -128.
      push(1'b0, 10, 1'b0, 123, 1'b0, 1'b0, 1'b1);
      push(1'b0, 11, 1'b1, 0,   1'b0, 1'b0, 1'b1);
      for (int k = 3; k <= 25; k++)
         push(1'b0, 1 + 5 * k, 1'b1, 0, 1'b0, 1'b0, 1'b1);
      push(1'b1, 0, 1'b1, 0, 1'b1, 1'b0, 1'b1);
      repeat (6) begin
         send(0, 0);
         wait_ticks(5);
      end
      check("rest_stopped", int'(stopped), 1);

      // Watchdog: m1 at +10, then silence.
      push(1'b1, 123, 1'b1, 0, 1'b0, 1'b0, 1'b1);
      push(1'b1, 118, 1'b1, 0, 1'b0, 1'b0, 1'b1);
`ifdef MOTOR_CMD_SHAPER_WDOG_EN
      push(1'b1, 118, 1'b1, 0, 1'b0, 1'b1, 1'b0);
      push(1'b1, 123, 1'b1, 0, 1'b0, 1'b1, 1'b0);
      push(1'b1, 0,   1'b1, 0, 1'b1, 1'b1, 1'b1);
`endif
      send(10, 0);
      wait_ticks(7);
      check("wdog_early_trip", int'(wdog_trip), 0);
      wait_ticks(1);
`ifdef MOTOR_CMD_SHAPER_WDOG_EN
      check("wdog_trip", int'(wdog_trip), 1);
      check("wdog_ready", int'(cmd_ready), 0);
      wait_ticks(3);
      check("wdog_idle_ready", int'(cmd_ready), 1);
      check("wdog_sticky", int'(wdog_trip), 1);
      check("wdog_p1", int'(motor1_period), 0);
`else
      check("wdog_trip", int'(wdog_trip), 0);
      check("wdog_ready", int'(cmd_ready), 1);
      wait_ticks(3);
      check("wdog_hold_p1", int'(motor1_period), 118);
`endif

      // Next accept clears the trip; ramp to +15.
`ifdef MOTOR_CMD_SHAPER_WDOG_EN
      push(1'b1, 0,   1'b1, 0, 1'b1, 1'b0, 1'b1);
      push(1'b1, 123, 1'b1, 0, 1'b0, 1'b0, 1'b1);
      push(1'b1, 118, 1'b1, 0, 1'b0, 1'b0, 1'b1);
`endif
      push(1'b1, 113, 1'b1, 0, 1'b0, 1'b0, 1'b1);
      send(15, 0);
      wait_ticks(4);
      check("rerun_p1", int'(motor1_period), 113);
      check("rerun_trip", int'(wdog_trip), 0);

      // Asynchronous reset between clock edges.
      push(1'b1, 0, 1'b1, 0, 1'b1, 1'b0, 1'b1);
      #2 reset = 1'b0;
      #1;
      check("areset_p1", int'(motor1_period), 0);
      check("areset_s1", int'(motor1_sign), 1);
      check("areset_stopped", int'(stopped), 1);
      check("areset_trip", int'(wdog_trip), 0);
      check("areset_ready", int'(cmd_ready), 1);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);

      check("queue_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/motor_cmd_shaper.md
# motor_cmd_shaper

Upstream stage of `motor_controller`. Accepts signed per-wheel speed commands from the balance control path over a valid/ready handshake and slew-limits each wheel toward its target once per ramp tick. It converts the ramped speeds into the `motor1_sign`/`motor1_period`/`motor2_sign`/`motor2_period` bus that `motor_controller` consumes. A command watchdog ramps both wheels to a stop if the command stream dies.

## Interface
- `TICK_DIV`, 1000: `clk` cycles per ramp tick (≥2).
- `STEP`, 1: maximum change of each wheel speed per tick, in speed units (1..127).
- `WDOG_TICKS`, 255: number of ticks without an accepted command before a trip (≥1).
- `PERIOD_MIN`, 7'd10: smallest period ever emitted for a nonzero speed.
- `clk` in 1: single clock; every register is on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: a command is present.
- `cmd_ready` out 1: the block can accept a command.
- `cmd_m1` in 8: signed two's-complement target speed for motor 1.
- `cmd_m2` in 8: signed two's-complement target speed for motor 2.
- `motor1_sign` out 1: 1 means forward (speed ≥ 0); 0 means reverse.
- `motor1_period` out 7: step period; 0 means stopped.
- `motor2_sign` out 1: same encoding as `motor1_sign`.
- `motor2_period` out 7: same encoding as `motor1_period`.
- `stopped` out 1: both ramped speeds are 0.
- `wdog_trip` out 1: sticky watchdog-trip flag.

## Operation
- **Accept.** A command is accepted on a rising edge where `cmd_valid && cmd_ready`. At that edge `tgt1`/`tgt2` load the command; the value -128 is clamped to -127.
- **Tick.** A free-running counter cycles 0..`TICK_DIV`-1. The tick strobe is the cycle in which the counter is at `TICK_DIV`-1.
- **Ramp (per wheel, on the tick strobe only).** `cur` is a signed 8-bit register. Compute `d = tgt - cur` at 9-bit width.
  - If |d| ≤ `STEP`: `cur <= tgt`.
  - Otherwise: `cur <= cur ± STEP`, moving toward `tgt`.
  - A reversal passes through 0, emitting a period of 0 for one tick.
- **Mapping (per wheel).** `mag = |cur|`.
  - Sign = (`cur` ≥ 0).
  - Period = 0 if `mag` = 0; otherwise max(`PERIOD_MIN`, 128 − `mag`).
  - Example: `mag` 1 → period 127.
- **FSM.**
  - IDLE (reset state): `cmd_ready`=1. The watchdog is halted and cleared. An accepted command moves to RUN.
  - RUN: `cmd_ready`=1. The watchdog counter increments on each tick and clears on each accept. When it reaches `WDOG_TICKS`, go to FAULT.
  - FAULT: `cmd_ready`=0, `wdog_trip` is set, and `tgt1` = `tgt2` = 0, so the ramp continues toward 0. Once both `cur` are 0, go to IDLE.
- **wdog_trip clear.** `wdog_trip` remains 1 in IDLE after a trip. It is cleared at the next accepted command.

## Timing
- **Reset values** (asynchronous assert, held while `reset`=0):
  - `cmd_ready`=1, `stopped`=1, `wdog_trip`=0
  - `motor1_sign`=`motor2_sign`=1, `motor1_period`=`motor2_period`=0
  - FSM=IDLE; `tgt`, `cur`, tick counter and watchdog counter all 0
- **Latency.** Accept edge → `tgt` valid. The next tick-strobe edge updates `cur`. The sign, period and `stopped` outputs are registered and reflect `cur` one edge later.
- **Accept on a tick cycle.** The ramp on that edge uses the old `tgt`. The watchdog clears: accept wins over increment.
- **Watchdog trip on an accept cycle.** Cannot occur, because the accept clears the counter first.
- **Handshake.** `cmd_ready` is a registered function of the FSM state only and does not depend on `cmd_valid`. While `cmd_ready`=0, commands are ignored and not queued.
- **Reset mid-ramp.** All outputs return to their reset values immediately. No ramp-down is performed.

## Configuration
- `MOTOR_CMD_SHAPER_WDOG_EN`
  - **Defined:** the watchdog counter, the FAULT state and `wdog_trip` behave as above.
  - **Undefined:** no watchdog logic. FAULT is unreachable, `wdog_trip` is tied to 0, `cmd_ready` is constant 1 after reset, and the last target is held indefinitely.

## Test plan
Benches use `TICK_DIV`=4, `STEP`=5, `WDOG_TICKS`=8 and `PERIOD_MIN`=10. The macro is defined unless stated.
- **Reset:** hold `reset`=0 → `cmd_ready`=1, `stopped`=1, `wdog_trip`=0, both signs 1, both periods 0.
- **Ramp up:** accept `cmd_m1`=+20, `cmd_m2`=-10.
  - Motor 1 periods over successive ticks: 123, 118, 113, 108; sign 1.
  - Motor 2: sign 0, periods 123, 118, then held.
  - `stopped` falls one edge after the first tick.
- **Reversal:** m1 at +10, accept -10 → speeds 5, 0, -5, -10 → periods 123, 0, 123, 118; sign 1, 1, 0, 0.
- **Clamp:** accept `cmd_m1`=-128 → settles at `cur`=-127, period 10 (128−127=1 floored to `PERIOD_MIN`), sign 0.
- **Watchdog:** m1 at +10, then no command for 8 ticks.
  - `wdog_trip`=1 and `cmd_ready`=0; periods go 123, then 0.
  - FSM returns to IDLE with `cmd_ready`=1 and `wdog_trip` still 1.
  - The next accept clears `wdog_trip`.
  - With the macro undefined, the same stimulus holds period 118 indefinitely.
- **Async reset mid-ramp:** drop `reset` between clock edges while m1 is at +15 → all outputs return to reset values immediately, without waiting for `clk`.
